// File: rtl/dispatch_buffer4_pkg.sv
// dispatch_buffer4 shared package: field widths, offsets, unpack convention.
// Shared with queue4in1 / issue_slot; optional feature macro DISPBUF_SKIP_DEAD_EN.
package dispatch_buffer4_pkg;

    localparam int W_UOP    = 7;
    localparam int DEF_WREG = 3;
    localparam int DEF_WTAG = 3;
    localparam int DEF_WBRM = 3;

    // Low fields sit at fixed offsets regardless of parameterisation.
    localparam int P1_OFF  = 0;
    localparam int P2_OFF  = 1;
    localparam int VAL_OFF = 2;
    localparam int PR1_OFF = 3;

    function automatic int inst_width(input int wr, input int wt, input int wb);
        return W_UOP + wb + wt + 3 * wr + 3;
    endfunction

    function automatic int pr2_off(input int wr);
        return 3 + wr;
    endfunction

    function automatic int prd_off(input int wr);
        return 3 + 2 * wr;
    endfunction

    function automatic int tag_off(input int wr);
        return 3 + 3 * wr;
    endfunction

    function automatic int brm_off(input int wr, input int wt);
        return 3 + 3 * wr + wt;
    endfunction

    function automatic int uop_off(input int wr, input int wt, input int wb);
        return 3 + 3 * wr + wt + wb;
    endfunction

    // Unpack view of one instruction at default widths, MSB first.
    typedef struct packed {
        logic [W_UOP-1:0]    uop;
        logic [DEF_WBRM-1:0] brm;
        logic [DEF_WTAG-1:0] tag;
        logic [DEF_WREG-1:0] prd;
        logic [DEF_WREG-1:0] pr2;
        logic [DEF_WREG-1:0] pr1;
        logic                val;
        logic                p2;
        logic                p1;
    } inst_t;

endpackage

// File: rtl/dispatch_buffer4_uop_update.sv
// dispbuf_uop_update: combinational wakeup and branch-kill of one instruction.
// Used by dispatch_buffer4 (feature macro DISPBUF_SKIP_DEAD_EN lives in the top).
module dispbuf_uop_update
    import dispatch_buffer4_pkg::*;
#(
    parameter  int WIDTH_REG = DEF_WREG,
    parameter  int WIDTH_TAG = DEF_WTAG,
    parameter  int WIDTH_BRM = DEF_WBRM,
    localparam int WIDTH     = inst_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM)
) (
    input  logic [WIDTH-1:0]       i_inst,
    input  logic [4*WIDTH_REG-1:0] i_wdest4x,
    input  logic [WIDTH_BRM-1:0]   i_BrKill,
    output logic [WIDTH-1:0]       o_inst
);

    localparam int PR2_O = pr2_off(WIDTH_REG);
    localparam int BRM_O = brm_off(WIDTH_REG, WIDTH_TAG);

    logic [WIDTH_REG-1:0] pr1;
    logic [WIDTH_REG-1:0] pr2;
    logic [WIDTH_REG-1:0] lane;
    logic [WIDTH_BRM-1:0] brm;
    logic                 hit1;
    logic                 hit2;

    // Match both sources against every live writeback lane, then apply kill.
    always_comb begin
        pr1    = i_inst[PR1_OFF +: WIDTH_REG];
        pr2    = i_inst[PR2_O +: WIDTH_REG];
        brm    = i_inst[BRM_O +: WIDTH_BRM];
        hit1   = 1'b0;
        hit2   = 1'b0;
        lane   = '0;
        for (int k = 0; k < 4; k++) begin
            lane = i_wdest4x[k*WIDTH_REG +: WIDTH_REG];
            if (lane != '0) begin
                if (lane == pr1) hit1 = 1'b1;
                if (lane == pr2) hit2 = 1'b1;
            end
        end
        o_inst = i_inst;
        if (hit1) o_inst[P1_OFF] = 1'b1;
        if (hit2) o_inst[P2_OFF] = 1'b1;
        if ((brm & i_BrKill) != '0) o_inst[VAL_OFF] = 1'b0;
    end

endmodule

// File: rtl/dispatch_buffer4.sv
// dispatch_buffer4: 4-wide group FIFO between rename and queue4in1.
// DISPBUF_SKIP_DEAD_EN: auto-pop head groups whose lanes are all killed.
module dispatch_buffer4
    import dispatch_buffer4_pkg::*;
#(
    parameter  int WIDTH_REG = DEF_WREG,
    parameter  int WIDTH_TAG = DEF_WTAG,
    parameter  int WIDTH_BRM = DEF_WBRM,
    parameter  int DEPTH     = 4,
    localparam int WIDTH     = inst_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM),
    localparam int CW        = $clog2(DEPTH) + 1,
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [WIDTH-1:0]       i_inst1,
    input  logic [WIDTH-1:0]       i_inst2,
    input  logic [WIDTH-1:0]       i_inst3,
    input  logic [WIDTH-1:0]       i_inst4,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [WIDTH-1:0]       o_inst1,
    output logic [WIDTH-1:0]       o_inst2,
    output logic [WIDTH-1:0]       o_inst3,
    output logic [WIDTH-1:0]       o_inst4,
    output logic                   o_valid,
    input  logic                   i_ready,
    input  logic [4*WIDTH_REG-1:0] i_wdest4x,
    input  logic [WIDTH_BRM-1:0]   i_BrKill,
    output logic [CW-1:0]          o_count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem    [DEPTH][4];
    logic [WIDTH-1:0] upd    [DEPTH][4];
    logic [WIDTH-1:0] in_raw [4];
    logic [WIDTH-1:0] in_upd [4];
    logic [WIDTH-1:0] head   [4];

    logic [PW-1:0] rp;
    logic [PW-1:0] wp;
    logic [CW-1:0] count;
    logic          non_empty;
    logic          push;
    logic          pop;
    logic          skip;

    assign in_raw[0] = i_inst1;
    assign in_raw[1] = i_inst2;
    assign in_raw[2] = i_inst3;
    assign in_raw[3] = i_inst4;

    for (genvar d = 0; d < DEPTH; d++) begin : g_st
        for (genvar l = 0; l < 4; l++) begin : g_ln
            dispbuf_uop_update #(
                .WIDTH_REG (WIDTH_REG),
                .WIDTH_TAG (WIDTH_TAG),
                .WIDTH_BRM (WIDTH_BRM)
            ) u_upd (
                .i_inst    (mem[d][l]),
                .i_wdest4x (i_wdest4x),
                .i_BrKill  (i_BrKill),
                .o_inst    (upd[d][l])
            );
        end
    end

    for (genvar l = 0; l < 4; l++) begin : g_in
        dispbuf_uop_update #(
            .WIDTH_REG (WIDTH_REG),
            .WIDTH_TAG (WIDTH_TAG),
            .WIDTH_BRM (WIDTH_BRM)
        ) u_upd (
            .i_inst    (in_raw[l]),
            .i_wdest4x (i_wdest4x),
            .i_BrKill  (i_BrKill),
            .o_inst    (in_upd[l])
        );
    end

    assign non_empty = (count != '0);

    // Head view reuses the stored-path update; val forced low when empty.
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            head[l] = upd[rp][l];
            if (!non_empty) head[l][VAL_OFF] = 1'b0;
        end
    end

`ifdef DISPBUF_SKIP_DEAD_EN
    logic head_live;
    assign head_live = head[0][VAL_OFF] | head[1][VAL_OFF]
                     | head[2][VAL_OFF] | head[3][VAL_OFF];
    assign skip      = non_empty && !head_live;
    assign o_valid   = non_empty && head_live;
`else
    assign skip      = 1'b0;
    assign o_valid   = non_empty;
`endif

    assign o_inst1 = head[0];
    assign o_inst2 = head[1];
    assign o_inst3 = head[2];
    assign o_inst4 = head[3];
    assign o_ready = (count != FULL);
    assign o_count = count;
    assign push    = i_valid && o_ready;
    assign pop     = (o_valid && i_ready) || skip;

    // Storage absorbs wakeup/kill every cycle; push overwrites at wp.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int d = 0; d < DEPTH; d++) begin
                for (int l = 0; l < 4; l++) begin
                    mem[d][l] <= '0;
                end
            end
        end else begin
            for (int d = 0; d < DEPTH; d++) begin
                for (int l = 0; l < 4; l++) begin
                    mem[d][l] <= upd[d][l];
                end
            end
            if (push) begin
                for (int l = 0; l < 4; l++) begin
                    mem[wp][l] <= in_upd[l];
                end
            end
        end
    end

    // Pointers and occupancy; reset wins over push and pop.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop)  rp <= rp + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dispatch_buffer4.sv
// tb_dispatch_buffer4: directed checks of dispatch_buffer4 at default widths.
// Dead-group expectations follow DISPBUF_SKIP_DEAD_EN when defined.
module tb_dispatch_buffer4;
    import dispatch_buffer4_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [24:0] i_inst1, i_inst2, i_inst3, i_inst4;
    logic        i_valid;
    logic        o_ready;
    logic [24:0] o_inst1, o_inst2, o_inst3, o_inst4;
    logic        o_valid;
    logic        i_ready;
    logic [11:0] i_wdest4x;
    logic [2:0]  i_BrKill;
    logic [2:0]  o_count;

    int total = 0;
    int bad   = 0;

    dispatch_buffer4 dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_inst1   (i_inst1),
        .i_inst2   (i_inst2),
        .i_inst3   (i_inst3),
        .i_inst4   (i_inst4),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_inst1   (o_inst1),
        .o_inst2   (o_inst2),
        .o_inst3   (o_inst3),
        .o_inst4   (o_inst4),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .i_wdest4x (i_wdest4x),
        .i_BrKill  (i_BrKill),
        .o_count   (o_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [24:0] mk(input int uop, input int brm,
        input int tag, input int prd, input int pr2, input int pr1,
        input int val, input int p2, input int p1);
        inst_t t;
        t.uop = uop[6:0];
        t.brm = brm[2:0];
        t.tag = tag[2:0];
        t.prd = prd[2:0];
        t.pr2 = pr2[2:0];
        t.pr1 = pr1[2:0];
        t.val = val[0];
        t.p2  = p2[0];
        t.p1  = p1[0];
        return t;
    endfunction

    function automatic logic [24:0] grp(input int g, input int l);
        return mk(g * 4 + l, 0, l, l + 1, 0, 0, 1, 0, 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load(input int g);
        i_inst1 = grp(g, 0);
        i_inst2 = grp(g, 1);
        i_inst3 = grp(g, 2);
        i_inst4 = grp(g, 3);
    endtask

    logic [24:0] w1, w2, k1, k2, k3, k4;

    initial begin
        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_wdest4x = '0;
        i_BrKill  = '0;
        load(0);
        tick();
        tick();
        i_rst_n = 1'b1;
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_val1", 32'(o_inst1[2]), 32'd0);

        // fill: 5 pushes, 5th dropped
        i_valid = 1'b1;
        for (int g = 0; g < 5; g++) begin
            load(g);
            tick();
        end
        i_valid = 1'b0;
        #1;
        check("fill_count", 32'(o_count), 32'd4);
        check("fill_ready", 32'(o_ready), 32'd0);
        check("fill_valid", 32'(o_valid), 32'd1);

        // drain in order
        i_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            check($sformatf("drain%0d_v", g), 32'(o_valid), 32'd1);
            check($sformatf("drain%0d_l1", g), 32'(o_inst1), 32'(grp(g, 0)));
            check($sformatf("drain%0d_l4", g), 32'(o_inst4), 32'(grp(g, 3)));
            tick();
        end
        i_ready = 1'b0;
        #1;
        check("drain_count", 32'(o_count), 32'd0);
        check("drain_valid", 32'(o_valid), 32'd0);
        check("drain_ready", 32'(o_ready), 32'd1);

        // stored wakeup on lane 2, pr1=110
        w1 = mk(40, 0, 0, 1, 2, 0, 1, 0, 0);
        w2 = mk(41, 0, 1, 2, 5, 6, 1, 0, 0);
        i_inst1 = w1;
        i_inst2 = w2;
        i_inst3 = grp(9, 2);
        i_inst4 = grp(9, 3);
        i_valid = 1'b1;
        tick();
        i_valid   = 1'b0;
        i_wdest4x = {3'b110, 3'b000, 3'b000, 3'b000};
        #1;
        check("wk_count", 32'(o_count), 32'd1);
        check("wk_same", 32'(o_inst2), 32'(mk(41, 0, 1, 2, 5, 6, 1, 0, 1)));
        check("wk_zero_lane", 32'(o_inst1), 32'(w1));
        tick();
        i_wdest4x = '0;
        #1;
        check("wk_hold", 32'(o_inst2), 32'(mk(41, 0, 1, 2, 5, 6, 1, 0, 1)));
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;

        // kill only BrM=010 lanes
        k1 = mk(50, 2, 0, 1, 3, 4, 1, 1, 0);
        k2 = mk(51, 1, 1, 2, 3, 4, 1, 0, 1);
        k3 = mk(52, 2, 2, 3, 5, 6, 1, 0, 0);
        k4 = mk(53, 1, 3, 4, 5, 6, 1, 1, 1);
        i_inst1 = k1;
        i_inst2 = k2;
        i_inst3 = k3;
        i_inst4 = k4;
        i_valid = 1'b1;
        tick();
        i_valid  = 1'b0;
        i_BrKill = 3'b010;
        #1;
        check("kill_l1", 32'(o_inst1), 32'(mk(50, 2, 0, 1, 3, 4, 0, 1, 0)));
        check("kill_l2", 32'(o_inst2), 32'(k2));
        check("kill_l3", 32'(o_inst3), 32'(mk(52, 2, 2, 3, 5, 6, 0, 0, 0)));
        tick();
        i_BrKill = '0;
        #1;
        check("kill_hold1", 32'(o_inst1), 32'(mk(50, 2, 0, 1, 3, 4, 0, 1, 0)));
        check("kill_hold4", 32'(o_inst4), 32'(k4));
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;

        // concurrent push/pop with count=2, pointers wrap
        i_valid = 1'b1;
        load(10);
        tick();
        load(11);
        tick();
        i_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            load(12 + c);
            #1;
            check($sformatf("cc%0d_count", c), 32'(o_count), 32'd2);
            check($sformatf("cc%0d_head", c), 32'(o_inst1), 32'(grp(10 + c, 0)));
            tick();
        end
        i_valid = 1'b0;
        #1;
        check("cc_count", 32'(o_count), 32'd2);
        check("cc_h13", 32'(o_inst3), 32'(grp(13, 2)));
        tick();
        #1;
        check("cc_h14", 32'(o_inst2), 32'(grp(14, 1)));
        tick();
        i_ready = 1'b0;
        #1;
        check("cc_empty", 32'(o_count), 32'd0);

        // dead group followed by a live group
        i_inst1 = mk(60, 4, 0, 1, 0, 0, 1, 0, 0);
        i_inst2 = mk(61, 4, 1, 2, 0, 0, 1, 0, 0);
        i_inst3 = mk(62, 4, 2, 3, 0, 0, 1, 0, 0);
        i_inst4 = mk(63, 4, 3, 4, 0, 0, 1, 0, 0);
        i_valid = 1'b1;
        tick();
        load(20);
        tick();
        i_valid  = 1'b0;
        i_BrKill = 3'b100;
        #1;
        check("dead_vals", 32'({o_inst1[2], o_inst2[2], o_inst3[2], o_inst4[2]}),
              32'd0);
`ifdef DISPBUF_SKIP_DEAD_EN
        check("dead_valid", 32'(o_valid), 32'd0);
        tick();
        i_BrKill = '0;
        #1;
        check("dead_count", 32'(o_count), 32'd1);
        check("dead_next", 32'(o_inst1), 32'(grp(20, 0)));
`else
        check("dead_valid", 32'(o_valid), 32'd1);
        tick();
        i_BrKill = '0;
        #1;
        check("dead_count", 32'(o_count), 32'd2);
        check("dead_held", 32'(o_inst1), 32'(mk(60, 4, 0, 1, 0, 0, 0, 0, 0)));
`endif

        // mid-stream reset beats a concurrent push
        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_ready = 1'b1;
        load(21);
        tick();
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        #1;
        check("mrst_count", 32'(o_count), 32'd0);
        check("mrst_valid", 32'(o_valid), 32'd0);
        check("mrst_ready", 32'(o_ready), 32'd1);
        check("mrst_val", 32'(o_inst1[2]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dispatch_buffer4.md
# dispatch_buffer4

Four-wide dispatch buffer that sits directly upstream of the 4-in/1-out issue queue (`queue4in1`). It accepts renamed 4-instruction groups, holds up to DEPTH groups in a FIFO, and presents the head group to the issue queue with a valid/ready handshake. While instructions wait, it applies writeback wakeup to their `p1`/`p2` ready bits and branch-kill to their `val` bit, so no wakeup or kill is lost between rename and issue.

## Interface
Parameters:
- `WIDTH_REG`, 3, physical register tag width
- `WIDTH_TAG`, 3, ROB tag width
- `WIDTH_BRM`, 3, branch mask width
- `DEPTH`, 4, FIFO depth in groups; power of two, at least 2
- Derived: `WIDTH = 7 + WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + 3`. Instruction layout, MSB first: `{UOP[6:0], BrM, Tag, prd, pr2, pr1, val, p2, p1}`.

Ports:
- `i_clk` in 1: clock. One clock; the reset is synchronous and active-low.
- `i_rst_n` in 1: synchronous active-low reset.
- `i_inst1`..`i_inst4` in WIDTH each: incoming group, lane 1 oldest.
- `i_valid` in 1: push request.
- `o_ready` out 1: buffer can accept a group (`count < DEPTH`).
- `o_inst1`..`o_inst4` out WIDTH each: head group.
- `o_valid` out 1: head group present.
- `i_ready` in 1: issue queue accepts head (drives its `i_en`).
- `i_wdest4x` in 4*WIDTH_REG: four writeback destination tags; an all-zero lane means no writeback.
- `i_BrKill` in WIDTH_BRM: branch kill mask.
- `o_count` out $clog2(DEPTH)+1: occupied groups.

## Operation
- **Push** = `i_valid && o_ready`. The group is written at the write pointer; the write pointer wraps modulo DEPTH.
- **Pop** = `o_valid && i_ready`. The read pointer advances and wraps modulo DEPTH.
- **Wakeup**, per instruction, every cycle, on stored entries and on the group being pushed:
  - If `pr1` equals any nonzero `i_wdest4x` lane, set `p1`.
  - If `pr2` equals any nonzero lane, set `p2`.
  - Ready bits never clear except on overwrite.
- **Kill**, per instruction, every cycle, same scope as wakeup: if `(BrM & i_BrKill) != 0`, clear `val`. Other fields are unchanged.
- **Output forwarding:** `o_inst*` are the stored head entries with the current cycle's wakeup and kill applied combinationally. The issue queue therefore sees wakeups that coincide with the pop cycle.
- **Ordering:** lane order within a group is preserved, and groups leave in FIFO order.
- **Full:** `o_ready=0`; `i_valid` is ignored with no corruption. `o_ready` depends only on `count`, never on `i_ready`.
- **Empty:** `o_valid=0`; `o_inst*` are don't-care, but their `val` bits read 0.
- **Push and pop in the same cycle:** both occur and `count` is unchanged. This is legal at full only when `count < DEPTH` was already true for the push.
- **Push while empty:** there is no flow-through; the group appears on `o_inst*` the next cycle.

## Timing
- Push-to-`o_valid` latency is 1 cycle. Pop takes effect at the next clock edge.
- Wakeup and kill reach stored state at the next edge, and reach `o_inst*` in the same cycle.
- Reset, applied at any time including mid-operation, takes effect at the next edge:
  - pointers = 0, `count` = 0, `o_valid` = 0, `o_ready` = 1.
  - All stored `val` bits = 0; other stored fields are unspecified.
- Reset takes priority over push and pop in the same cycle.

## Configuration
- **`DISPBUF_SKIP_DEAD_EN` defined:** a head group whose four `val` bits are all 0 after kill is popped automatically, one group per cycle.
  - `o_valid` is 0 for that group.
  - The auto-pop does not require `i_ready`.
- **Undefined:** dead groups are presented normally (`o_valid=1`, all `val=0`) and wait for `i_ready`.

## Structure
- **Shared package:**
  - field width defaults and the `WIDTH` formula
  - field bit offsets (`UOP`, `BrM`, `Tag`, `prd`, `pr2`, `pr1`, `val`, `p2`, `p1`)
  - the instruction-field unpack convention shared with `queue4in1` and `issue_slot`
- **Sub-module `dispbuf_uop_update`:** combinational wakeup and kill for one instruction, taking `i_wdest4x` and `i_BrKill`. It is instantiated 4*DEPTH times for storage and 4 times for the push path; the output path reuses the head's stored-path instances.
- Pointers and `count` live in the top level; storage uses `register` instances or a plain array.

## Test plan
All cases use default parameters (WIDTH=25).
- **Reset then idle:** `o_valid=0`, `o_ready=1`, `o_count=0`.
- **Fill and drain:** push 5 groups with `i_ready=0`.
  - Result: `o_count=4`, `o_ready=0`, 5th group dropped.
  - Then hold `i_ready=1`: groups emerge in order over 4 cycles and `o_count` returns to 0.
- **Stored wakeup:** stored head lane 2 has `pr1=3'b110`, `p1=0`; drive `i_wdest4x={3'b110,0,0,0}` for one cycle.
  - Result: `o_inst2` `p1=1` in that same cycle, and it stays 1 afterwards.
- **Kill:** buffered lanes have `BrM=3'b010` and `3'b001`; drive `i_BrKill=3'b010`.
  - Result: only the `3'b010` lanes show `val=0`; all other fields are unchanged.
- **Concurrent push/pop:** with `o_count=2`, assert `i_valid` and `i_ready` for 3 cycles.
  - Result: `o_count` stays 2, FIFO order is intact, and the pointers wrap correctly.
- **Dead group and mid-stream reset:**
  - Kill all lanes of the head group. With `DISPBUF_SKIP_DEAD_EN` it is skipped without `i_ready`; without it, it is presented with `o_valid=1`.
  - Then assert `i_rst_n=0` for one edge: the next cycle shows empty state.
